mem_arbiter: RTL and testbench

Two-port arbiter that shares the single synchronous-read RAM between the CPU instruction-fetch port and data load/store port. Both ports use a valid/ready request handshake with a fixed one-cycle response. Data accesses win by default, with an anti-starvation counter that promotes a waiting fetch. Sits between `cpu` and `ram`; the RAM needs no changes.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_stats.sv | 52 +++++
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and address-slice constants for the CPU/RAM port arbiter.
// The statistics feature is selected by MEM_ARB_STATS_EN in mem_arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int WORD_ADDR_W = 22;
  localparam int ADDR_LSB    = 2;
  localparam int ADDR_MSB    = ADDR_LSB + WORD_ADDR_W - 1;

  // Byte address to RAM word address; the low byte-offset bits are dropped.
  function automatic logic [WORD_ADDR_W-1:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr[ADDR_MSB:ADDR_LSB];
  endfunction

endpackage

// File: rtl/mem_arb_stats.sv
// Grant and conflict counters for mem_arbiter; built only when MEM_ARB_STATS_EN is defined.
// Counters wrap at 2^32 and clear takes priority over increment.
module mem_arb_stats
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        i_grant,
  input  logic        d_grant,
  input  logic        conflict,
  output logic [31:0] i_grants,
  output logic [31:0] d_grants,
  output logic [31:0] conflicts
);

  logic [31:0] i_grants_q, i_grants_d;
  logic [31:0] d_grants_q, d_grants_d;
  logic [31:0] conflicts_q, conflicts_d;

  always_comb begin
    i_grants_d  = i_grants_q;
    d_grants_d  = d_grants_q;
    conflicts_d = conflicts_q;
    if (clr) begin
      i_grants_d  = '0;
      d_grants_d  = '0;
      conflicts_d = '0;
    end else begin
      if (i_grant)  i_grants_d  = i_grants_q + 32'd1;
      if (d_grant)  d_grants_d  = d_grants_q + 32'd1;
      if (conflict) conflicts_d = conflicts_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_grants_q  <= '0;
      d_grants_q  <= '0;
      conflicts_q <= '0;
    end else begin
      i_grants_q  <= i_grants_d;
      d_grants_q  <= d_grants_d;
      conflicts_q <= conflicts_d;
    end
  end

  assign i_grants  = i_grants_q;
  assign d_grants  = d_grants_q;
  assign conflicts = conflicts_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read RAM between the fetch and data ports; data wins unless a
// fetch has waited MAX_WAIT cycles. Statistics counters exist only with MEM_ARB_STATS_EN.
//
// owner_q   | meaning
// OWN_NONE  | no access issued last cycle, no response this cycle
// OWN_I     | fetch granted last cycle, i_resp_valid this cycle
// OWN_D     | data granted last cycle, d_resp_valid this cycle
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [31:0]            i_addr,
  output logic                   i_resp_valid,
  output logic [31:0]            i_rdata,
  input  logic                   d_valid,
  output logic                   d_ready,
  input  logic [31:0]            d_addr,
  input  logic [31:0]            d_wdata,
  input  logic [3:0]             d_wstrb,
  output logic                   d_resp_valid,
  output logic [31:0]            d_rdata,
  output logic [3:0]             ram_wen,
  output logic [WORD_ADDR_W-1:0] ram_addr,
  output logic [31:0]            ram_wdata,
  input  logic [31:0]            ram_rdata,
  input  logic                   stat_clr,
  output logic [31:0]            stat_i_grants,
  output logic [31:0]            stat_d_grants,
  output logic [31:0]            stat_conflicts
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             promoted;

  always_comb begin
    promoted   = (wait_cnt_q == CNT_W'(MAX_WAIT));
    d_ready    = d_valid & ~(promoted & i_valid) & ~rst;
    i_ready    = i_valid & ~d_ready & ~rst;

    ram_addr   = '0;
    ram_wen    = '0;
    ram_wdata  = '0;
    owner_d    = OWN_NONE;
    if (d_ready) begin
      ram_addr  = word_addr(d_addr);
      ram_wen   = d_wstrb;
      ram_wdata = d_wdata;
      owner_d   = OWN_D;
    end else if (i_ready) begin
      ram_addr  = word_addr(i_addr);
      owner_d   = OWN_I;
    end

    // Saturates so the promotion holds until the fetch is actually taken.
    wait_cnt_d = '0;
    if (i_valid && !i_ready) begin
      wait_cnt_d = promoted ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      wait_cnt_q <= '0;
    end else begin
      owner_q    <= owner_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign i_resp_valid = (owner_q == OWN_I);
  assign d_resp_valid = (owner_q == OWN_D);
  assign i_rdata      = ram_rdata;
  assign d_rdata      = ram_rdata;

`ifdef MEM_ARB_STATS_EN
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:ADDR_MSB+1], i_addr[ADDR_LSB-1:0],
                              d_addr[31:ADDR_MSB+1], d_addr[ADDR_LSB-1:0]};

  mem_arb_stats u_stats (
    .clk       (clk),
    .rst       (rst),
    .clr       (stat_clr),
    .i_grant   (i_ready),
    .d_grant   (d_ready),
    .conflict  (i_valid & d_valid),
    .i_grants  (stat_i_grants),
    .d_grants  (stat_d_grants),
    .conflicts (stat_conflicts)
  );
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:ADDR_MSB+1], i_addr[ADDR_LSB-1:0],
                              d_addr[31:ADDR_MSB+1], d_addr[ADDR_LSB-1:0], stat_clr};

  assign stat_i_grants  = '0;
  assign stat_d_grants  = '0;
  assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter with a byte-writable synchronous-read RAM model.
// Expected statistics follow MEM_ARB_STATS_EN.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_ready, i_resp_valid;
  logic [31:0] i_addr, i_rdata;
  logic        d_valid, d_ready, d_resp_valid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic [3:0]  ram_wen;
  logic [21:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        stat_clr;
  logic [31:0] stat_i_grants, stat_d_grants, stat_conflicts;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    owner_e      own;
    logic [31:0] data;
    logic        check;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  logic        loaded = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr),
    .i_resp_valid(i_resp_valid), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_resp_valid(d_resp_valid), .d_rdata(d_rdata),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .stat_clr(stat_clr), .stat_i_grants(stat_i_grants),
    .stat_d_grants(stat_d_grants), .stat_conflicts(stat_conflicts)
  );

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'h0000_0000;
      1:       return 32'h0010_0113;
      2:       return 32'h1122_3344;
      default: return 32'(i) * 32'h0101_0101;
    endcase
  endfunction

  // RAM: registered read returns the pre-write word on a write cycle.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      loaded <= 1'b1;
    end else begin
      ram_rdata <= mem[ram_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (ram_wen[b]) mem[ram_addr[7:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats(input string tag, input int ei, input int ed, input int ec);
`ifdef MEM_ARB_STATS_EN
    chk({tag, ":stat_i_grants"},  stat_i_grants,  32'(ei));
    chk({tag, ":stat_d_grants"},  stat_d_grants,  32'(ed));
    chk({tag, ":stat_conflicts"}, stat_conflicts, 32'(ec));
`else
    chk({tag, ":stat_i_grants"},  stat_i_grants,  32'd0 + 32'(ei - ei));
    chk({tag, ":stat_d_grants"},  stat_d_grants,  32'd0 + 32'(ed - ed));
    chk({tag, ":stat_conflicts"}, stat_conflicts, 32'd0 + 32'(ec - ec));
`endif
  endtask

  // Inputs are already driven; check this cycle's response and grant, then advance.
  task automatic do_cycle(input string tag, input logic ei, input logic ed);
    exp_t        e;
    exp_t        n;
    logic [31:0] ea;
    #1;
    e = exp_q.pop_front();
    chk({tag, ":i_resp_valid"}, 32'(i_resp_valid), 32'(e.own == OWN_I));
    chk({tag, ":d_resp_valid"}, 32'(d_resp_valid), 32'(e.own == OWN_D));
    if (e.check && e.own == OWN_I) chk({tag, ":i_rdata"}, i_rdata, e.data);
    if (e.check && e.own == OWN_D) chk({tag, ":d_rdata"}, d_rdata, e.data);
    chk({tag, ":i_ready"}, 32'(i_ready), 32'(ei));
    chk({tag, ":d_ready"}, 32'(d_ready), 32'(ed));
    chk({tag, ":ram_wen"}, 32'(ram_wen), ed ? 32'(d_wstrb) : 32'd0);
    ea = ed ? {10'd0, d_addr[23:2]} : (ei ? {10'd0, i_addr[23:2]} : 32'd0);
    chk({tag, ":ram_addr"}, 32'(ram_addr), ea);
    if (ed) begin
      n.own   = OWN_D;
      n.data  = ref_mem[d_addr[9:2]];
      n.check = (d_wstrb == 4'h0);
      for (int b = 0; b < 4; b++)
        if (d_wstrb[b]) ref_mem[d_addr[9:2]][b*8 +: 8] = d_wdata[b*8 +: 8];
    end else if (ei) begin
      n.own   = OWN_I;
      n.data  = ref_mem[i_addr[9:2]];
      n.check = 1'b1;
    end else begin
      n.own   = OWN_NONE;
      n.data  = '0;
      n.check = 1'b0;
    end
    exp_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    string pat;
    pat = "DDDDIDDDDI";
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    rst = 1'b1; stat_clr = 1'b0;
    i_valid = 1'b0; i_addr = '0;
    d_valid = 1'b1; d_addr = '0; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
    exp_q.push_back('{OWN_NONE, 32'd0, 1'b0});
    @(posedge clk); #1;

    do_cycle("rst0", 1'b0, 1'b0);
    do_cycle("rst1", 1'b0, 1'b0);
    chk("rst:mem0", mem[0], 32'h0000_0000);
    chk_stats("rst", 0, 0, 0);

    rst = 1'b0; d_valid = 1'b0; d_wstrb = 4'h0;
    i_valid = 1'b1; i_addr = 32'h4;
    do_cycle("fetch", 1'b1, 1'b0);
    i_valid = 1'b0;
    do_cycle("fetch_resp", 1'b0, 1'b0);

    d_valid = 1'b1; d_addr = 32'h0; d_wdata = 32'h1; d_wstrb = 4'hF;
    do_cycle("store", 1'b0, 1'b1);
    d_wstrb = 4'h0;
    do_cycle("load", 1'b0, 1'b1);
    d_valid = 1'b0;
    do_cycle("load_resp", 1'b0, 1'b0);
    chk("store:mem0", mem[0], 32'h1);

    d_valid = 1'b1; d_addr = 32'h8; d_wdata = 32'h0000_AB00; d_wstrb = 4'h2;
    do_cycle("strb", 1'b0, 1'b1);
    d_wstrb = 4'h0;
    do_cycle("strb_load", 1'b0, 1'b1);
    d_valid = 1'b0;
    do_cycle("strb_resp", 1'b0, 1'b0);
    chk("strb:mem2", mem[2], 32'h1122_AB44);

    // Clear lands on a grant cycle: clear must win.
    stat_clr = 1'b1; i_valid = 1'b1; i_addr = 32'hC;
    do_cycle("clr", 1'b1, 1'b0);
    stat_clr = 1'b0; i_valid = 1'b0;
    do_cycle("clr_resp", 1'b0, 1'b0);
    chk_stats("clr", 0, 0, 0);

    i_valid = 1'b1; i_addr = 32'h10;
    d_valid = 1'b1; d_addr = 32'h14; d_wstrb = 4'h0;
    for (int c = 0; c < 10; c++) begin
      if (pat[c] == "I") do_cycle($sformatf("starve%0d", c), 1'b1, 1'b0);
      else               do_cycle($sformatf("starve%0d", c), 1'b0, 1'b1);
    end
    i_valid = 1'b0; d_valid = 1'b0;
    do_cycle("starve_end", 1'b0, 1'b0);
    chk_stats("starve", 2, 8, 10);

    i_valid = 1'b1; i_addr = 32'h4;
    do_cycle("rstresp_grant", 1'b1, 1'b0);
    rst = 1'b1; i_valid = 1'b0; d_valid = 1'b1; d_addr = 32'h0; d_wstrb = 4'h0;
    do_cycle("rstresp_n1", 1'b0, 1'b0);
    do_cycle("rstresp_n2", 1'b0, 1'b0);
    rst = 1'b0; d_valid = 1'b0;
    do_cycle("rstresp_idle", 1'b0, 1'b0);
    chk_stats("rstresp", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
